alu_op_decoder: RTL and testbench
=================================

# alu_op_decoder

Registered decode stage that turns a 32-bit RV32I instruction into the control word consumed by the execute-stage `alu`: 4-bit op code, register indices, immediate, and operand selects. It sits between fetch and execute and uses a valid/ready handshake on both sides, with a flush that discards in-flight entries. The op code it produces is the sole driver of the ALU `op_i` input.

## Interface

Parameters:
- `XLEN`, 32, data/immediate/PC width; only 32 is supported.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-high.
- `valid_i` in 1: an instruction is offered.
- `ready_o` out 1: the stage accepts the offered instruction this cycle.
- `instr_i` in 32: instruction word.
- `pc_i` in 32: PC of the instruction.
- `flush_i` in 1: discard all held and offered entries.
- `valid_o` out 1: a decoded entry is presented.
- `ready_i` in 1: execute consumes the entry this cycle.
- `op_o` out 4: ALU op. 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- `rs1_o`, `rs2_o`, `rd_o` out 5 each: register indices.
- `imm_o` out 32: decoded immediate.
- `a_sel_o` out 2: A operand. 00 rs1, 01 pc, 10 zero.
- `b_sel_o` out 1: B operand. 0 rs2, 1 imm.
- `we_o` out 1: rd writeback enable.
- `illegal_o` out 1: unsupported or malformed encoding.
- `pc_o` out 32: PC carried with the entry.

## Operation

Decode rules:
- OP (0110011): `b_sel` is 0. `op` comes from funct3/funct7.
  - 000 → ADD when funct7 = 0x00, SUB when funct7 = 0x20.
  - 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR.
  - 101 → SRL when funct7 = 0x00, SRA when funct7 = 0x20.
  - 110 → OR, 111 → AND.
  - Any other funct7 is illegal.
- OP-IMM (0010011): `b_sel` is 1 and the immediate is the I-immediate, sign-extended. Same funct3 map, with these exceptions:
  - funct3 000 is always ADD.
  - SLLI requires funct7 = 0x00; `imm` = shamt[4:0] zero-extended.
  - SRLI/SRAI use funct7 0x00/0x20 respectively; `imm` = shamt[4:0] zero-extended.
- LUI (0110111): ADD, a_sel zero, b_sel imm, imm = {instr[31:12], 12'b0}.
- AUIPC (0010111): ADD, a_sel pc, b_sel imm, U-immediate.
- LOAD (0000011): ADD, rs1 + I-immediate, `we` = 1.
- STORE (0100011): ADD, rs1 + S-immediate, `we` = 0.
- All other opcodes are illegal.
- `we_o` is 1 for OP, OP-IMM, LUI, AUIPC and LOAD. It is forced to 0 whenever `rd` = 0 or the entry is illegal.
- Illegal entries still flow through the stage with `illegal_o` = 1, `op_o` = 0000, `we_o` = 0 and `imm_o` = 0.
- Decode is combinational on `instr_i` and the result is registered on acceptance.
- Handshake:
  - Input transfer happens when `valid_i && ready_o`.
  - Output transfer happens when `valid_o && ready_i`.
  - While `valid_o` = 1 and `ready_i` = 0, every output holds stable.
- Entries leave in acceptance order; none are dropped or duplicated.
- `flush_i` = 1:
  - All held entries are invalidated at the next edge.
  - An input offered in the same cycle is not accepted.
  - `ready_o` is forced to 0 during the flush cycle.
  - Flush takes priority over a simultaneous accept or consume.

## Timing

- Latency: an instruction accepted at edge N is presented on `valid_o` after edge N; one cycle, no bubble.
- Throughput: one instruction per cycle while `ready_i` = 1.
- Reset values:
  - `valid_o` = 0.
  - `op_o` = 0, `rs1_o`/`rs2_o`/`rd_o` = 0, `imm_o` = 0, `pc_o` = 0.
  - `a_sel_o` = 0, `b_sel_o` = 0, `we_o` = 0, `illegal_o` = 0.
  - `ready_o` = 0 while `rst_i` is high, and 1 on the first cycle after release.
- Reset asserted mid-stream clears all entries immediately (asynchronous); nothing is replayed.

## Configuration

- `ALU_DEC_SKID_EN` defined:
  - Two-entry skid buffer; `ready_o` is a registered flop with no combinational path from `ready_i`.
  - `ready_o` = 0 only when both entries are full.
  - A simultaneous accept and consume while one entry is held keeps occupancy at 1.
- `ALU_DEC_SKID_EN` undefined:
  - Single output register; `ready_o` = !`valid_o` || `ready_i` (combinational).
  - Simultaneous accept and consume replaces the entry in the same edge.
- Decode results, latency and flush behaviour are identical in both builds.

## Test plan

- `add x3,x1,x2` = 0x002081B3, `ready_i` = 1 → next cycle: `valid_o` = 1, op 0000, rs1 1, rs2 2, rd 3, b_sel 0, a_sel 00, we 1, illegal 0.
- `sub x5,x6,x7` = 0x407302B3 → op 0001. `srai x1,x2,3` = 0x40315093 → op 0111, imm 0x00000003, b_sel 1. 0x60315093 (bad funct7) → illegal 1, op 0000, we 0.
- `addi x1,x0,-1` = 0xFFF00093 → op 0000, imm 0xFFFFFFFF. `lui x1,0x12345` = 0x123450B7 → op 0000, a_sel 10, imm 0x12345000.
- Stream 6 instructions back-to-back, `ready_i` low for 3 cycles mid-stream:
  - With skid: `ready_o` falls after 2 held, outputs stable while stalled.
  - Without skid: `ready_o` tracks `ready_i`.
  - Both builds: all 6 emerge in order, none lost or duplicated.
- `flush_i` pulsed with 2 held entries and `valid_i` = 1 → next cycle `valid_o` = 0; the offered instruction is not accepted and must be re-offered.
- `rst_i` asserted asynchronously between edges while `valid_o` = 1 → `valid_o` and all outputs go to 0 immediately; first post-reset accept yields its output one cycle later.

Source files
------------

// File: rtl/alu_op_decoder.sv
// RV32I decode stage feeding the execute-stage ALU: registered control word with valid/ready and flush.
// Define ALU_DEC_SKID_EN for a two-entry skid buffer with a registered ready_o.
module alu_op_decoder #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [3:0]      op_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic [1:0]      a_sel_o,
  output logic            b_sel_o,
  output logic            we_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  imm;
    logic [1:0]       a_sel;
    logic             b_sel;
    logic             we;
    logic             illegal;
    logic [XLEN-1:0]  pc;
  } entry_t;

  // funct3 to ALU op; alt selects SUB/SRA on the 000/101 slots
  function automatic logic [OP_W-1:0] f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  f3_to_op = 4'b0010;
      3'b010:  f3_to_op = 4'b0011;
      3'b011:  f3_to_op = 4'b0100;
      3'b100:  f3_to_op = 4'b0101;
      3'b101:  f3_to_op = alt ? 4'b0111 : 4'b0110;
      3'b110:  f3_to_op = 4'b1000;
      default: f3_to_op = 4'b1001;
    endcase
  endfunction

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i_ext;
  logic [XLEN-1:0] imm_s_ext;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  entry_t          dec;

  assign opc       = instr_i[6:0];
  assign f3        = instr_i[14:12];
  assign f7        = instr_i[31:25];
  assign imm_i_ext = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s_ext = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u     = XLEN'({instr_i[31:12], 12'b0});
  assign shamt     = {{(XLEN-5){1'b0}}, instr_i[24:20]};

  always_comb begin
    dec         = '0;
    dec.rs1     = instr_i[19:15];
    dec.rs2     = instr_i[24:20];
    dec.rd      = instr_i[11:7];
    dec.pc      = pc_i;
    dec.b_sel   = 1'b1;
    dec.we      = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.b_sel   = 1'b0;
        dec.op      = f3_to_op(f3, f7 == F7_ALT);
        dec.illegal = !((f7 == F7_ZERO) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec.op  = f3_to_op(f3, (f3 == 3'b101) && (f7 == F7_ALT));
        dec.imm = ((f3 == 3'b001) || (f3 == 3'b101)) ? shamt : imm_i_ext;
        dec.illegal = ((f3 == 3'b001) && (f7 != F7_ZERO)) ||
                      ((f3 == 3'b101) && (f7 != F7_ZERO) && (f7 != F7_ALT));
      end
      OPC_LUI: begin
        dec.a_sel = 2'b10;
        dec.imm   = imm_u;
      end
      OPC_AUIPC: begin
        dec.a_sel = 2'b01;
        dec.imm   = imm_u;
      end
      OPC_LOAD:  dec.imm = imm_i_ext;
      OPC_STORE: begin
        dec.imm = imm_s_ext;
        dec.we  = 1'b0;
      end
      default:   dec.illegal = 1'b1;
    endcase
    // Illegal entries carry only their fields, PC and the illegal flag
    if (dec.illegal) begin
      dec.op    = '0;
      dec.imm   = '0;
      dec.a_sel = '0;
      dec.b_sel = 1'b0;
      dec.we    = 1'b0;
    end
    if (dec.rd == '0) dec.we = 1'b0;
  end

  entry_t head_q;
  logic   valid_q;
  logic   push;
  logic   pop;

  assign push = valid_i && ready_o;
  assign pop  = valid_q && ready_i;

`ifdef ALU_DEC_SKID_EN
  entry_t skid_q;
  logic   full_q;
  logic   ready_q;

  assign ready_o = ready_q && !flush_i && !rst_i;

  // head_q is presented; skid_q catches one extra entry while stalled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (full_q) begin
      if (pop) begin
        head_q  <= skid_q;
        full_q  <= 1'b0;
        ready_q <= 1'b1;
      end
    end else if (valid_q) begin
      if (push && pop) begin
        head_q <= dec;
      end else if (push) begin
        skid_q  <= dec;
        full_q  <= 1'b1;
        ready_q <= 1'b0;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
    end else if (push) begin
      head_q  <= dec;
      valid_q <= 1'b1;
    end
  end
`else
  assign ready_o = !rst_i && !flush_i && (!valid_q || ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (push) begin
      head_q  <= dec;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  assign valid_o   = valid_q;
  assign op_o      = head_q.op;
  assign rs1_o     = head_q.rs1;
  assign rs2_o     = head_q.rs2;
  assign rd_o      = head_q.rd;
  assign imm_o     = head_q.imm;
  assign a_sel_o   = head_q.a_sel;
  assign b_sel_o   = head_q.b_sel;
  assign we_o      = head_q.we;
  assign illegal_o = head_q.illegal;
  assign pc_o      = head_q.pc;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: decode vector table plus stall, flush and async-reset sequences.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [3:0]  op_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic [1:0]  a_sel_o;
  logic        b_sel_o;
  logic        we_o;
  logic        illegal_o;
  logic [31:0] pc_o;

  int n_chk = 0;
  int n_fail = 0;

  alu_op_decoder #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .valid_o(valid_o),
    .ready_i(ready_i), .op_o(op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .imm_o(imm_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o), .we_o(we_o),
    .illegal_o(illegal_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [3:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [1:0]  a_sel;
    logic        b_sel;
    logic        we;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  initial begin
    int cnt, sent, got;
    logic stalled_prev;
    logic [31:0] held_pc, held_imm;
    logic exp_ready;
    logic push, pop;

    //          instr         op    rs1 rs2 rd  imm           a  b  we ill
    vec[0]  = '{32'h002081B3, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0};   // add x3,x1,x2
    vec[1]  = '{32'h407302B3, 4'd1, 5'd6, 5'd7, 5'd5, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0};   // sub
    vec[2]  = '{32'h40315093, 4'd7, 5'd2, 5'd3, 5'd1, 32'h3, 2'd0, 1'b1, 1'b1, 1'b0};   // srai
    vec[3]  = '{32'h60315093, 4'd0, 5'd2, 5'd3, 5'd1, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1};   // bad funct7
    vec[4]  = '{32'hFFF00093, 4'd0, 5'd0, 5'd31, 5'd1, 32'hFFFFFFFF, 2'd0, 1'b1, 1'b1, 1'b0}; // addi -1
    vec[5]  = '{32'h123450B7, 4'd0, 5'd8, 5'd3, 5'd1, 32'h12345000, 2'd2, 1'b1, 1'b1, 1'b0}; // lui
    vec[6]  = '{32'h00001117, 4'd0, 5'd0, 5'd0, 5'd2, 32'h00001000, 2'd1, 1'b1, 1'b1, 1'b0}; // auipc
    vec[7]  = '{32'h0082A203, 4'd0, 5'd5, 5'd8, 5'd4, 32'h8, 2'd0, 1'b1, 1'b1, 1'b0};   // lw
    vec[8]  = '{32'hFE63AE23, 4'd0, 5'd7, 5'd6, 5'd28, 32'hFFFFFFFC, 2'd0, 1'b1, 1'b0, 1'b0}; // sw
    vec[9]  = '{32'h00208033, 4'd0, 5'd1, 5'd2, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b0};   // add x0
    vec[10] = '{32'h0000007F, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1};   // bad opcode
    vec[11] = '{32'h01F11093, 4'd2, 5'd2, 5'd31, 5'd1, 32'h1F, 2'd0, 1'b1, 1'b1, 1'b0}; // slli 31
    vec[12] = '{32'h402091B3, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 2'd0, 1'b0, 1'b0, 1'b1};   // sll w/ 0x20
    vec[13] = '{32'h7FF2C293, 4'd5, 5'd5, 5'd31, 5'd5, 32'h7FF, 2'd0, 1'b1, 1'b1, 1'b0}; // xori
    vec[14] = '{32'h00B574B3, 4'd9, 5'd10, 5'd11, 5'd9, 32'h0, 2'd0, 1'b0, 1'b1, 1'b0}; // and

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_fields", {op_o, rs1_o, rs2_o, rd_o, a_sel_o, b_sel_o, we_o, illegal_o}, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1 chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Decode table, back-to-back at full throughput
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      instr_i = vec[i].instr;
      pc_i    = 32'h1000 + 32'(i * 4);
      ready_i = 1'b1;
      #1 chk("tbl_ready", 32'(ready_o), 32'd1);
      @(posedge clk);
      #1;
      chk("tbl_valid", 32'(valid_o), 32'd1);
      chk("tbl_op", 32'(op_o), 32'(vec[i].op));
      chk("tbl_rs1", 32'(rs1_o), 32'(vec[i].rs1));
      chk("tbl_rs2", 32'(rs2_o), 32'(vec[i].rs2));
      chk("tbl_rd", 32'(rd_o), 32'(vec[i].rd));
      chk("tbl_imm", imm_o, vec[i].imm);
      chk("tbl_we", 32'(we_o), 32'(vec[i].we));
      chk("tbl_illegal", 32'(illegal_o), 32'(vec[i].ill));
      chk("tbl_pc", pc_o, 32'h1000 + 32'(i * 4));
      if (!vec[i].ill) begin
        chk("tbl_a_sel", 32'(a_sel_o), 32'(vec[i].a_sel));
        chk("tbl_b_sel", 32'(b_sel_o), 32'(vec[i].b_sel));
      end
    end
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);
    #1 chk("drain_valid", 32'(valid_o), 32'd0);

    // Stream 6 with ready_i low for 3 cycles; occupancy model predicts valid/ready
    cnt = 0; sent = 0; got = 0; stalled_prev = 1'b0; held_pc = '0; held_imm = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      valid_i = (sent < 6);
      instr_i = (32'(sent) << 20) | (32'(sent + 1) << 7) | 32'h13;
      pc_i    = 32'h2000 + 32'(sent * 4);
      ready_i = !(cyc >= 3 && cyc <= 5);
      #1;
      chk("str_valid", 32'(valid_o), 32'(cnt != 0));
`ifdef ALU_DEC_SKID_EN
      exp_ready = (cnt < 2);
`else
      exp_ready = (cnt == 0) || ready_i;
`endif
      chk("str_ready", 32'(ready_o), 32'(exp_ready));
      if (stalled_prev && valid_o) begin
        chk("str_hold_pc", pc_o, held_pc);
        chk("str_hold_imm", imm_o, held_imm);
      end
      push = valid_i && ready_o;
      pop  = valid_o && ready_i;
      if (pop) begin
        chk("str_order_pc", pc_o, 32'h2000 + 32'(got * 4));
        chk("str_order_rd", 32'(rd_o), 32'(got + 1));
        chk("str_order_imm", imm_o, 32'(got));
        got++;
      end
      stalled_prev = valid_o && !ready_i;
      held_pc  = pc_o;
      held_imm = imm_o;
      if (push) sent++;
      cnt = cnt + int'(push) - int'(pop);
    end
    chk("str_all_out", 32'(got), 32'd6);
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (2) @(posedge clk);

    // Flush with entries held and a new instruction offered
    @(negedge clk);
    ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h3000;
    @(negedge clk);
    instr_i = 32'h407302B3; pc_i = 32'h3004;
    @(negedge clk);
    flush_i = 1'b1; instr_i = 32'h123450B7; pc_i = 32'h3008;
    #1 chk("flush_ready", 32'(ready_o), 32'd0);
    @(posedge clk);
    #1 chk("flush_valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk);
    #1 chk("flush_not_accepted", 32'(valid_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b1;
    #1 chk("reoffer_ready", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("reoffer_valid", 32'(valid_o), 32'd1);
    chk("reoffer_pc", pc_o, 32'h3008);
    chk("reoffer_imm", imm_o, 32'h12345000);
    @(negedge clk);
    valid_i = 1'b0;
    @(posedge clk);

    // Asynchronous reset between edges while an entry is presented
    @(negedge clk);
    valid_i = 1'b1; ready_i = 1'b0; instr_i = 32'h123450B7; pc_i = 32'h4000;
    @(posedge clk);
    #1 chk("arst_pre_valid", 32'(valid_o), 32'd1);
    valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_imm", imm_o, 32'd0);
    chk("arst_pc", pc_o, 32'd0);
    chk("arst_fields", {op_o, rs1_o, rs2_o, rd_o, a_sel_o, b_sel_o, we_o, illegal_o}, 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0; ready_i = 1'b1; valid_i = 1'b1; instr_i = 32'h002081B3; pc_i = 32'h5000;
    #1 chk("arst_post_ready", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("arst_post_valid", 32'(valid_o), 32'd1);
    chk("arst_post_rd", 32'(rd_o), 32'd3);
    chk("arst_post_pc", pc_o, 32'h5000);
    @(negedge clk);
    valid_i = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
